gt_rx_frame_checker: RTL

- Receive-side checker for the periodic K-marker test stream the GT transmit path emits.
- Sits on the GT rxusrclk domain after the 8b10b decoder and takes 16-bit rxdata/rxcharisk.
- Recovers byte alignment and frame phase, and declares lock.
- Once locked, counts word errors, emits a byte-aligned data stream and a frame-start strobe for link bring-up and loopback tests.

---
 rtl/gt_frame_pkg.sv | 10 +
 rtl/gt_byte_aligner.sv | 41 ++++
 rtl/gt_rx_frame_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gt_frame_pkg.sv
// gt_frame_pkg: K-marker test pattern definitions shared by the GT tx pattern generator and rx checker
package gt_frame_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} frame_state_t;
  localparam logic [7:0]  K28_5           = 8'hbc;
  localparam logic [7:0]  K28_0           = 8'h1c;
  localparam int          FRAME_PERIOD    = 64;
  localparam int          FRAME_MARK_LEN  = 2;
  localparam logic [15:0] FRAME_MARK_WORD = {K28_0, K28_5};
  localparam logic [15:0] FRAME_FILL_WORD = 16'h0000;
endpackage

// File: rtl/gt_byte_aligner.sv
// gt_byte_aligner: straight/rotated candidate words, marker detect on both, registered aligned output
module gt_byte_aligner import gt_frame_pkg::*; #(
  parameter logic [15:0] MARK_WORD = FRAME_MARK_WORD
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        rxvalid,
  input  logic [15:0] rxdata,
  input  logic [1:0]  rxcharisk,
  input  logic        byte_sel,
  output logic        a0_hit,
  output logic        a1_hit,
  output logic [15:0] cand_data,
  output logic [1:0]  cand_charisk,
  output logic [15:0] aligned_data,
  output logic [1:0]  aligned_charisk
);
  logic [7:0]  prev_hi;
  logic        prev_k_hi;
  logic [15:0] a1_data;
  logic [1:0]  a1_charisk;
  assign a1_data      = {rxdata[7:0], prev_hi};
  assign a1_charisk   = {rxcharisk[0], prev_k_hi};
  assign a0_hit       = rxdata == MARK_WORD && rxcharisk == 2'b11;
  assign a1_hit       = a1_data == MARK_WORD && a1_charisk == 2'b11;
  assign cand_data    = byte_sel ? a1_data : rxdata;
  assign cand_charisk = byte_sel ? a1_charisk : rxcharisk;
  // Keep the upper byte of the last valid word for the rotated candidate and register the selected word
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      prev_hi         <= '0;
      prev_k_hi       <= 1'b0;
      aligned_data    <= '0;
      aligned_charisk <= '0;
    end else if (rxvalid) begin
      prev_hi         <= rxdata[15:8];
      prev_k_hi       <= rxcharisk[1];
      aligned_data    <= cand_data;
      aligned_charisk <= cand_charisk;
    end
endmodule

// File: rtl/gt_rx_frame_checker.sv
// gt_rx_frame_checker: K-marker frame lock, word error count and frame strobe (optional GT_RX_FRAME_CHECKER_TSTAMP_EN timestamp)
module gt_rx_frame_checker import gt_frame_pkg::*; #(
  parameter int          DWIDTH     = 16,
  parameter int          PERIOD     = FRAME_PERIOD,
  parameter int          MARK_LEN   = FRAME_MARK_LEN,
  parameter logic [15:0] MARK_WORD  = FRAME_MARK_WORD,
  parameter logic [15:0] FILL_WORD  = FRAME_FILL_WORD,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              rxvalid,
  input  logic [DWIDTH-1:0] rxdata,
  input  logic [1:0]        rxcharisk,
  input  logic              err_clr,
  output logic [DWIDTH-1:0] aligned_data,
  output logic [1:0]        aligned_charisk,
  output logic              frame_start,
  output logic              byte_sel,
  output logic [1:0]        state,
  output logic              locked,
  output logic [15:0]       err_cnt,
  output logic [31:0]       marker_tstamp
);
  localparam int             PW       = $clog2(PERIOD);
  localparam logic [PW-1:0]  LAST     = PW'(PERIOD - 1);
  localparam logic [PW-1:0]  MLEN     = PW'(MARK_LEN);
  localparam logic [7:0]     LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0]     UNLOCK_N = 8'(UNLOCK_CNT);
  if (DWIDTH != 16) begin : g_dwidth_check
    $error("gt_rx_frame_checker supports DWIDTH=16 only");
  end
  frame_state_t  st, st_n;
  logic [PW-1:0] pos, pos_n;
  logic [7:0]    good_frames, good_n, bad_frames, bad_n;
  logic          frame_err, ferr_n, sel_n, fs_n;
  logic          a0_hit, a1_hit, word_err, frame_end, frame_bad;
  logic [15:0]   cand_data;
  logic [1:0]    cand_charisk;
  gt_byte_aligner #(.MARK_WORD(MARK_WORD)) u_aligner (
    .clk             (clk),
    .areset_n        (areset_n),
    .rxvalid         (rxvalid),
    .rxdata          (rxdata),
    .rxcharisk       (rxcharisk),
    .byte_sel        (byte_sel),
    .a0_hit          (a0_hit),
    .a1_hit          (a1_hit),
    .cand_data       (cand_data),
    .cand_charisk    (cand_charisk),
    .aligned_data    (aligned_data),
    .aligned_charisk (aligned_charisk)
  );
  assign word_err  = {cand_charisk, cand_data} != (pos < MLEN ? {2'b11, MARK_WORD} : {2'b00, FILL_WORD});
  assign frame_end = pos == LAST;
  assign frame_bad = frame_err || word_err;
  assign state     = st;
  assign locked    = st == LOCKED;
  // Frame tracking registers
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      st          <= HUNT;
      pos         <= '0;
      good_frames <= '0;
      bad_frames  <= '0;
      frame_err   <= 1'b0;
      byte_sel    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      st          <= st_n;
      pos         <= pos_n;
      good_frames <= good_n;
      bad_frames  <= bad_n;
      frame_err   <= ferr_n;
      byte_sel    <= sel_n;
      frame_start <= fs_n;
    end
  // Acquisition, frame-phase checking and lock/unlock decisions
  always_comb begin
    st_n   = st;
    pos_n  = pos;
    good_n = good_frames;
    bad_n  = bad_frames;
    ferr_n = frame_err;
    sel_n  = byte_sel;
    fs_n   = 1'b0;
    if (!rxvalid) begin
      st_n   = HUNT;
      pos_n  = '0;
      good_n = '0;
      bad_n  = '0;
      ferr_n = 1'b0;
    end else if (st == HUNT) begin
      if (a0_hit || a1_hit) begin
        st_n  = CHECK;
        pos_n = PW'(1);
        sel_n = !a0_hit;
      end
    end else begin
      pos_n = frame_end ? '0 : pos + 1'b1;
      if (st == CHECK) begin
        if (word_err) begin
          st_n   = HUNT;
          pos_n  = '0;
          good_n = '0;
        end else if (frame_end) begin
          good_n = good_frames + 1'b1;
          st_n   = good_n == LOCK_N ? LOCKED : CHECK;
        end
      end else begin
        fs_n   = pos == '0;
        ferr_n = frame_bad;
        if (frame_end) begin
          ferr_n = 1'b0;
          bad_n  = frame_bad ? bad_frames + 1'b1 : '0;
          if (bad_n == UNLOCK_N) begin
            st_n   = HUNT;
            pos_n  = '0;
            good_n = '0;
            bad_n  = '0;
          end
        end
      end
    end
  end
  // Saturating word error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (rxvalid && st == LOCKED && word_err && err_cnt != 16'hffff)
      err_cnt <= err_cnt + 1'b1;
`ifdef GT_RX_FRAME_CHECKER_TSTAMP_EN
  logic [31:0] cyc_cnt;
  // Free-running cycle counter sampled into marker_tstamp with each frame strobe
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      cyc_cnt       <= '0;
      marker_tstamp <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (fs_n)
        marker_tstamp <= cyc_cnt;
    end
`else
  assign marker_tstamp = '0;
`endif
endmodule
